// File: rtl/prism_sp_tx_dma_sched.sv
// prism_sp_tx_dma_sched
//   Schedules TX segment descriptors onto the DMA read engine. Software pushes
//   descriptors into a small queue. Each descriptor is issued to the engine
//   once, and the block waits for the engine to finish. At end of frame it
//   writes one meta word {segment count, frame length} into the TX meta FIFO.
//
// Optional build macro: PRISM_SP_TX_DMA_SCHED_SPACE_CHECK_EN
//   When this macro is defined, a segment is started only once the TX data
//   FIFO has room for it. When it is undefined, data_count is ignored.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   desc_*             descriptor push (valid/ready, addr, len, last)
//   mem_*              DMA engine command (start pulse, addr, len, cont) / busy
//   data_count         TX data FIFO occupancy in words
//   meta_full          TX meta FIFO full
//   meta_wr_en/_data   meta FIFO write: {seg_cnt[15:0], frame_len[15:0]}
//   queue_count, idle  status
//   frames_sent        frames whose meta word was written (wraps)
//   len_overflow       sticky: frame length accumulation wrapped
module prism_sp_tx_dma_sched #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned LEN_WIDTH       = 16,
  parameter int unsigned QUEUE_DEPTH     = 4,
  parameter int unsigned DATA_FIFO_WORDS = 1024,
  parameter int unsigned DATA_BYTES      = 8,
  parameter int unsigned COUNT_WIDTH     = 11
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           desc_valid,
  output logic                           desc_ready,
  input  logic [ADDR_WIDTH-1:0]          desc_addr,
  input  logic [LEN_WIDTH-1:0]           desc_len,
  input  logic                           desc_last,
  output logic                           mem_start,
  output logic [ADDR_WIDTH-1:0]          mem_addr,
  output logic [LEN_WIDTH-1:0]           mem_len,
  output logic                           mem_cont,
  input  logic                           mem_busy,
  input  logic [COUNT_WIDTH-1:0]         data_count,
  input  logic                           meta_full,
  output logic                           meta_wr_en,
  output logic [31:0]                    meta_wr_data,
  output logic [$clog2(QUEUE_DEPTH):0]   queue_count,
  output logic                           idle,
  output logic [31:0]                    frames_sent,
  output logic                           len_overflow
);

  localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_START, S_ARM, S_WAIT, S_DONE, S_META
  } state_t;

  state_t state_q, state_d;

  // Descriptor queue storage; pointers wrap naturally (depth is a power of two)
  logic [ADDR_WIDTH-1:0] q_addr [QUEUE_DEPTH];
  logic [LEN_WIDTH-1:0]  q_len  [QUEUE_DEPTH];
  logic                  q_last [QUEUE_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;

  // Working state for the current segment / frame
  logic                  cur_last;
  logic [LEN_WIDTH-1:0]  frame_len;
  logic [15:0]           seg_cnt;
  logic                  first;

  logic                  push, pop, space_ok, meta_fire;
  logic [LEN_WIDTH:0]    len_sum;

  assign desc_ready = (queue_count < CNT_W'(QUEUE_DEPTH));
  assign idle       = (state_q == S_IDLE) && (queue_count == '0);
  assign push       = desc_valid && desc_ready;
  assign meta_fire  = (state_q == S_META) && !meta_full;
  assign len_sum    = {1'b0, frame_len} + {1'b0, mem_len};

`ifdef PRISM_SP_TX_DMA_SCHED_SPACE_CHECK_EN
  localparam int unsigned SPACE_W = LEN_WIDTH + COUNT_WIDTH + $clog2(DATA_BYTES);
  logic [SPACE_W-1:0] free_words, free_bytes;

  // An occupancy above the FIFO depth is treated as no free space at all
  always_comb begin
    if (SPACE_W'(data_count) > SPACE_W'(DATA_FIFO_WORDS)) begin
      free_words = '0;
    end else begin
      free_words = SPACE_W'(DATA_FIFO_WORDS) - SPACE_W'(data_count);
    end
    free_bytes = free_words << $clog2(DATA_BYTES);
    space_ok   = (free_bytes >= SPACE_W'(mem_len));
  end
`else
  logic data_count_unused;
  assign data_count_unused = ^data_count;
  assign space_ok          = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (queue_count != '0) begin
          pop     = 1'b1;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (mem_len == '0) begin
          state_d = S_DONE;
        end else if (space_ok) begin
          state_d = S_START;
        end
      end
      S_START: state_d = S_ARM;
      S_ARM:   state_d = S_WAIT;
      S_WAIT:  if (!mem_busy) state_d = S_DONE;
      S_DONE:  state_d = cur_last ? S_META : S_IDLE;
      S_META:  if (!meta_full) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr] <= desc_addr;
      q_len[wr_ptr]  <= desc_len;
      q_last[wr_ptr] <= desc_last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      queue_count  <= '0;
      mem_start    <= 1'b0;
      mem_addr     <= '0;
      mem_len      <= '0;
      mem_cont     <= 1'b0;
      cur_last     <= 1'b0;
      frame_len    <= '0;
      seg_cnt      <= '0;
      first        <= 1'b1;
      len_overflow <= 1'b0;
      meta_wr_en   <= 1'b0;
      meta_wr_data <= '0;
      frames_sent  <= '0;
    end else begin
      state_q     <= state_d;
      queue_count <= queue_count + CNT_W'(push) - CNT_W'(pop);
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr   <= rd_ptr + PTR_W'(1);
        mem_addr <= q_addr[rd_ptr];
        mem_len  <= q_len[rd_ptr];
        cur_last <= q_last[rd_ptr];
        // first only changes in DONE/META, so it is already final at pop time
        mem_cont <= !first;
      end
      // Registered so that the pulse coincides exactly with the START state
      mem_start  <= (state_q == S_CHECK) && (state_d == S_START);
      meta_wr_en <= meta_fire;
      if (state_q == S_DONE) begin
        frame_len <= len_sum[LEN_WIDTH-1:0];
        seg_cnt   <= seg_cnt + 16'd1;
        first     <= 1'b0;
        if (len_sum[LEN_WIDTH]) len_overflow <= 1'b1;
      end
      if (meta_fire) begin
        meta_wr_data <= {seg_cnt, 16'(frame_len)};
        frames_sent  <= frames_sent + 32'd1;
        frame_len    <= '0;
        seg_cnt      <= '0;
        first        <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_prism_sp_tx_dma_sched.sv
module tb_prism_sp_tx_dma_sched;

  logic        clk, rst_n;
  logic        desc_valid, desc_ready, desc_last;
  logic [31:0] desc_addr;
  logic [15:0] desc_len;
  logic        mem_start, mem_cont, mem_busy;
  logic [31:0] mem_addr;
  logic [15:0] mem_len;
  logic [10:0] data_count;
  logic        meta_full, meta_wr_en;
  logic [31:0] meta_wr_data;
  logic [2:0]  queue_count;
  logic        idle;
  logic [31:0] frames_sent;
  logic        len_overflow;

  prism_sp_tx_dma_sched #(
    .ADDR_WIDTH(32), .LEN_WIDTH(16), .QUEUE_DEPTH(4),
    .DATA_FIFO_WORDS(1024), .DATA_BYTES(8), .COUNT_WIDTH(11)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_addr(desc_addr),
    .desc_len(desc_len), .desc_last(desc_last),
    .mem_start(mem_start), .mem_addr(mem_addr), .mem_len(mem_len),
    .mem_cont(mem_cont), .mem_busy(mem_busy),
    .data_count(data_count), .meta_full(meta_full),
    .meta_wr_en(meta_wr_en), .meta_wr_data(meta_wr_data),
    .queue_count(queue_count), .idle(idle), .frames_sent(frames_sent),
    .len_overflow(len_overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] addr;
    logic [15:0] len;
    logic        cont;
  } start_t;

  start_t      exp_start[$];
  logic [31:0] exp_meta[$];
  start_t      got_s;
  logic [31:0] got_m;

  int total = 0;
  int bad   = 0;
  int start_pulses = 0;
  int meta_pulses  = 0;
  int busy_cycles  = 10;

  // Reference model of the per-frame accumulation
  logic        m_first = 1'b1;
  logic [15:0] m_len   = '0;
  logic [15:0] m_seg   = '0;
  logic        m_ovf   = 1'b0;
  int          m_frames = 0;

  // DMA engine: busy from the cycle after the start pulse for busy_cycles edges
  initial begin
    mem_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_start === 1'b1) begin
        @(posedge clk);
        #1 mem_busy = 1'b1;
        repeat (busy_cycles) @(posedge clk);
        #1 mem_busy = 1'b0;
      end
    end
  end

  // Scoreboard: compare DMA starts and meta writes as they appear
  always @(negedge clk) begin
    if (rst_n && mem_start === 1'b1) begin
      start_pulses++;
      total++;
      if (exp_start.size() == 0) begin
        bad++;
        $display("FAIL start_unexpected: got addr=%h len=%h cont=%b, none expected",
                 mem_addr, mem_len, mem_cont);
      end else begin
        got_s = exp_start.pop_front();
        if ({mem_addr, mem_len, mem_cont} !== {got_s.addr, got_s.len, got_s.cont}) begin
          bad++;
          $display("FAIL start_cmd: got addr=%h len=%h cont=%b, want addr=%h len=%h cont=%b",
                   mem_addr, mem_len, mem_cont, got_s.addr, got_s.len, got_s.cont);
        end
      end
    end
    if (rst_n && meta_wr_en === 1'b1) begin
      meta_pulses++;
      total++;
      if (exp_meta.size() == 0) begin
        bad++;
        $display("FAIL meta_unexpected: got %h, none expected", meta_wr_data);
      end else begin
        got_m = exp_meta.pop_front();
        if (meta_wr_data !== got_m) begin
          bad++;
          $display("FAIL meta_word: got %h want %h", meta_wr_data, got_m);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one descriptor and record the expected DMA start / meta word
  task automatic push_desc(input logic [31:0] a, input logic [15:0] l, input logic last);
    int unsigned n = 0;
    logic [16:0] s;
    while (desc_ready !== 1'b1 && n < 200) begin
      tick(1);
      n++;
    end
    total++;
    if (desc_ready !== 1'b1) begin
      bad++;
      $display("FAIL push_ready_timeout: ready=%b want 1", desc_ready);
      return;
    end
    desc_valid = 1'b1;
    desc_addr  = a;
    desc_len   = l;
    desc_last  = last;
    tick(1);
    desc_valid = 1'b0;
    if (l != 16'd0) exp_start.push_back('{addr: a, len: l, cont: !m_first});
    s = {1'b0, m_len} + {1'b0, l};
    m_len = s[15:0];
    if (s[16]) m_ovf = 1'b1;
    m_seg++;
    m_first = 1'b0;
    if (last) begin
      exp_meta.push_back({m_seg, m_len});
      m_frames++;
      m_len   = '0;
      m_seg   = '0;
      m_first = 1'b1;
    end
  endtask

  task automatic wait_drain(input string name);
    int unsigned n = 0;
    while (!(idle === 1'b1 && mem_busy == 1'b0 && exp_start.size() == 0 &&
             exp_meta.size() == 0) && n < 500) begin
      tick(1);
      n++;
    end
    total++;
    if (n >= 500) begin
      bad++;
      $display("FAIL %s_drain: idle=%b starts_left=%0d metas_left=%0d, want idle with none left",
               name, idle, exp_start.size(), exp_meta.size());
    end
    total++;
    if (frames_sent !== 32'(m_frames)) begin
      bad++;
      $display("FAIL %s_frames_sent: got %0d want %0d", name, frames_sent, m_frames);
    end
    total++;
    if (len_overflow !== m_ovf) begin
      bad++;
      $display("FAIL %s_len_overflow: got %b want %b", name, len_overflow, m_ovf);
    end
  endtask

  task automatic check_reset_values(input string name);
    total++;
    if ({desc_ready, idle, mem_start, mem_cont, meta_wr_en, len_overflow} !== 6'b110000) begin
      bad++;
      $display("FAIL %s_flags: got ready/idle/start/cont/meta/ovf=%b want 110000", name,
               {desc_ready, idle, mem_start, mem_cont, meta_wr_en, len_overflow});
    end
    total++;
    if ({mem_addr, mem_len} !== 48'h0) begin
      bad++;
      $display("FAIL %s_mem_cmd: got addr=%h len=%h want 0", name, mem_addr, mem_len);
    end
    total++;
    if (meta_wr_data !== 32'h0 || frames_sent !== 32'h0) begin
      bad++;
      $display("FAIL %s_meta_regs: got data=%h frames=%0d want 0", name, meta_wr_data, frames_sent);
    end
    total++;
    if (queue_count !== 3'd0) begin
      bad++;
      $display("FAIL %s_queue_count: got %0d want 0", name, queue_count);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #10;
    check_reset_values("reset");
    #10 rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_single_frame();
    busy_cycles = 10;
    push_desc(32'h0000_1000, 16'd64, 1'b1);
    wait_drain("single");
  endtask

  task automatic test_multi_segment();
    busy_cycles = 4;
    push_desc(32'h0000_1100, 16'd100, 1'b0);
    push_desc(32'h0000_1200, 16'd200, 1'b0);
    push_desc(32'h0000_1300, 16'd0,   1'b1);
    wait_drain("multi");
  endtask

  task automatic test_meta_full();
    int p0, m0, n;
    busy_cycles = 3;
    meta_full = 1'b1;
    p0 = start_pulses;
    m0 = meta_pulses;
    push_desc(32'h0000_2000, 16'd16, 1'b1);
    n = 0;
    while (start_pulses == p0 && n < 50) begin
      tick(1);
      n++;
    end
    total++;
    if (start_pulses == p0) begin
      bad++;
      $display("FAIL metafull_start_timeout: got no start, want one");
    end
    tick(8);
    for (int i = 0; i < 4; i++) push_desc(32'h0000_2100 + 32'(i) * 32'h100, 16'd8, 1'b0);
    total++;
    if (queue_count !== 3'd4 || desc_ready !== 1'b0) begin
      bad++;
      $display("FAIL metafull_queue_full: got count=%0d ready=%b want 4/0", queue_count, desc_ready);
    end
    desc_valid = 1'b1;
    desc_addr  = 32'hDEAD_0000;
    desc_len   = 16'd1;
    desc_last  = 1'b1;
    tick(1);
    desc_valid = 1'b0;
    total++;
    if (queue_count !== 3'd4) begin
      bad++;
      $display("FAIL metafull_refused_push: got count=%0d want 4", queue_count);
    end
    tick(8);
    total++;
    if (meta_pulses != m0) begin
      bad++;
      $display("FAIL metafull_held: got %0d meta writes want 0", meta_pulses - m0);
    end
    meta_full = 1'b0;
    tick(3);
    total++;
    if (meta_pulses != m0 + 1) begin
      bad++;
      $display("FAIL metafull_release: got %0d meta writes want 1", meta_pulses - m0);
    end
    push_desc(32'h0000_2500, 16'd8, 1'b1);
    wait_drain("metafull");
  endtask

  task automatic test_space_check();
    int p0;
    busy_cycles = 2;
    p0 = start_pulses;
`ifdef PRISM_SP_TX_DMA_SCHED_SPACE_CHECK_EN
    data_count = 11'd1500;
    push_desc(32'h0000_3000, 16'd64, 1'b1);
    tick(8);
    total++;
    if (start_pulses != p0) begin
      bad++;
      $display("FAIL space_overrange_stall: got %0d starts want 0", start_pulses - p0);
    end
    data_count = 11'd1020;
    tick(6);
    total++;
    if (start_pulses != p0) begin
      bad++;
      $display("FAIL space_short_stall: got %0d starts want 0", start_pulses - p0);
    end
    data_count = 11'd1016;
    tick(1);
    total++;
    if (mem_start !== 1'b1) begin
      bad++;
      $display("FAIL space_release_start: got mem_start=%b want 1", mem_start);
    end
`else
    data_count = 11'd1020;
    push_desc(32'h0000_3000, 16'd64, 1'b1);
    tick(2);
    total++;
    if (mem_start !== 1'b1) begin
      bad++;
      $display("FAIL nospace_immediate_start: got mem_start=%b want 1", mem_start);
    end
`endif
    tick(1);
    data_count = 11'd0;
    wait_drain("space");
  endtask

  task automatic test_overflow();
    busy_cycles = 2;
    push_desc(32'h0000_4000, 16'hFFF0, 1'b0);
    push_desc(32'h0000_5000, 16'h0020, 1'b1);
    wait_drain("overflow");
    push_desc(32'h0000_7000, 16'd4, 1'b1);
    wait_drain("overflow_sticky");
  endtask

  task automatic test_reset_mid_wait();
    int p0, n;
    busy_cycles = 40;
    p0 = start_pulses;
    push_desc(32'h0000_6000, 16'd32, 1'b1);
    n = 0;
    while (start_pulses == p0 && n < 50) begin
      tick(1);
      n++;
    end
    push_desc(32'h0000_6100, 16'd8, 1'b1);
    tick(3);
    total++;
    if (queue_count !== 3'd1 || idle !== 1'b0) begin
      bad++;
      $display("FAIL midrst_pre: got count=%0d idle=%b want 1/0", queue_count, idle);
    end
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    exp_start.delete();
    exp_meta.delete();
    m_first = 1'b1;
    m_len = '0;
    m_seg = '0;
    m_ovf = 1'b0;
    m_frames = 0;
    #3 rst_n = 1'b1;
    tick(1);
    n = 0;
    while (mem_busy && n < 100) begin
      tick(1);
      n++;
    end
    busy_cycles = 2;
    push_desc(32'h0000_8000, 16'd12, 1'b1);
    wait_drain("after_rst");
  endtask

  initial begin
    desc_valid = 1'b0;
    desc_addr  = '0;
    desc_len   = '0;
    desc_last  = 1'b0;
    data_count = '0;
    meta_full  = 1'b0;
    test_reset();
    test_single_frame();
    test_multi_segment();
    test_meta_full();
    test_space_check();
    test_overflow();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prism_sp_tx_dma_sched.md
# prism_sp_tx_dma_sched

Hardware scheduler between the SP's TX command path and the TX data DMA read engine. Software pushes transmit segment descriptors (address, length, last-of-frame) into a small queue; the block issues them one at a time to the memory read engine, waits for completion and, at end of frame, writes one meta word to the TX meta FIFO. This replaces per-segment polling of DMA status and meta-FIFO-full by the SP core.

## Interface
Parameters:
- ADDR_WIDTH, 32, DMA byte address width
- LEN_WIDTH, 16, segment and frame length width (bytes)
- QUEUE_DEPTH, 4, descriptor queue entries (power of two, ≥2)
- DATA_FIFO_WORDS, 1024, TX data FIFO depth in words
- DATA_BYTES, 8, bytes per TX data FIFO word (power of two)
- COUNT_WIDTH, 11, width of data FIFO write count

Ports:
- clk  in  1  sole clock
- rst_n  in  1  asynchronous, active-low reset
- desc_valid  in  1  descriptor offered
- desc_ready  out  1  queue not full; reset 1
- desc_addr  in  ADDR_WIDTH  segment start address
- desc_len  in  LEN_WIDTH  segment length, bytes; 0 allowed
- desc_last  in  1  segment ends frame
- mem_start  out  1  one-cycle DMA start pulse; reset 0
- mem_addr  out  ADDR_WIDTH  DMA address; reset 0
- mem_len  out  LEN_WIDTH  DMA length; reset 0
- mem_cont  out  1  1 = not first segment of frame; reset 0
- mem_busy  in  1  DMA engine busy
- data_count  in  COUNT_WIDTH  TX data FIFO occupied words
- meta_full  in  1  TX meta FIFO full
- meta_wr_en  out  1  meta write strobe; reset 0
- meta_wr_data  out  32  {segment count[15:0], frame length[15:0]}; reset 0
- queue_count  out  $clog2(QUEUE_DEPTH)+1  queued descriptors; reset 0
- idle  out  1  state IDLE and queue empty; reset 1
- frames_sent  out  32  frames whose meta was written, wraps; reset 0
- len_overflow  out  1  sticky: frame length accumulation wrapped; reset 0

## Operation
- Queue: FIFO of {addr, len, last}; push on desc_valid & desc_ready; desc_ready = queue_count < QUEUE_DEPTH (combinational from registered count). Simultaneous push and pop when full: pop happens, push refused (ready was 0).
- Working state: frame_len (LEN_WIDTH), seg_cnt (16), first flag (reset 1).
- FSM states: IDLE, CHECK, START, ARM, WAIT, DONE, META.
- IDLE: queue non-empty → pop head into working regs, → CHECK.
- CHECK: len==0 → DONE (no DMA issued); else space check (see Configuration) pass → START, fail → stay.
- START: mem_start=1 for exactly this cycle; mem_addr/mem_len held from pop; mem_cont = !first; → ARM.
- ARM: one cycle, mem_busy ignored; → WAIT.
- WAIT: stay while mem_busy; mem_busy=0 → DONE.
- DONE: frame_len += len (mod 2^LEN_WIDTH; carry sets len_overflow), seg_cnt += 1, first=0; last → META, else IDLE.
- META: while meta_full stay; else meta_wr_en=1 one cycle with {seg_cnt, frame_len}, frames_sent += 1, frame_len=0, seg_cnt=0, first=1, → IDLE.
- Reset mid-operation: all state, queue and counters cleared immediately; an in-flight DMA is not aborted (engine owns it).

## Timing
- Push at edge N → queue_count incremented at N+1; popped at earliest N+1 (IDLE); mem_start earliest N+3.
- mem_start ≥1 cycle after ARM; mem_busy must rise by the cycle after start.
- Per-segment overhead: 5 cycles plus DMA busy time; META adds ≥1 cycle.
- All outputs registered except desc_ready and idle (decoded from registers).

## Configuration
- PRISM_SP_TX_DMA_SCHED_SPACE_CHECK_EN defined: CHECK passes only when (DATA_FIFO_WORDS − data_count)·DATA_BYTES ≥ len, computed at LEN_WIDTH+COUNT_WIDTH+$clog2(DATA_BYTES) bits, no truncation; data_count > DATA_FIFO_WORDS treated as zero free space.
- Not defined: CHECK always passes; data_count unused.

## Test plan
- Single frame, one desc {0x1000, 64, last}, busy 10 cycles → one mem_start with addr 0x1000, len 64, cont 0; meta_wr_data 0x0001_0040; frames_sent 1.
- Three-segment frame lens 100/200/0 (last on the zero) → two mem_starts, cont 0 then 1; meta 0x0003_012C.
- meta_full held 20 cycles at META → no meta_wr_en until release, then exactly one; queue continues accepting up to QUEUE_DEPTH, desc_ready=0 on 5th push.
- Space check on, data_count=1020, len 64 → stalls in CHECK; drop data_count to 1016 → start next cycle. Macro off: starts immediately.
- Lens 0xFFF0 + 0x0020 in one frame → meta length 0x0010, len_overflow=1 sticky.
- rst_n asserted during WAIT → all outputs at reset values asynchronously, queue_count 0, idle 1.
